// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;

  localparam int ZERO_REG_OFF = 0;
  localparam int ZERO_REG_ON  = 1;
  localparam int BYPASS_OFF   = 0;
  localparam int BYPASS_ON    = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations from decode, clears from writeback,
// and a one-cycle error pulse when decode reserves an already-busy register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = ZERO_REG_ON,
  parameter int AW       = clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_addr_i,
  input  logic [NUM_WR-1:0]    wr_clr_i,
  input  logic                 rsv_en_i,
  input  logic [AW-1:0]        rsv_addr_i,
  output logic [NUM_REGS-1:0]  busy_o,
  output logic                 rsv_err_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] clr_vec, rsv_vec;
  logic                rsv_err_q, rsv_err_d;
  logic                rsv_zero;

  assign rsv_zero = (ZERO_REG != 0) && (rsv_addr_i == '0);

  always_comb begin
    clr_vec = '0;
    rsv_vec = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_en_i[j] && wr_clr_i[j] && (wr_addr_i[j*AW +: AW] == AW'(r)))
          clr_vec[r] = 1'b1;
      end
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rsv_en_i && (rsv_addr_i == AW'(r)))
        rsv_vec[r] = 1'b1;
    end
    // A same-cycle reserve represents a new producer, so it overrides the clear.
    busy_d = (busy_q & ~clr_vec) | rsv_vec;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
    rsv_err_d = rsv_en_i && busy_q[rsv_addr_i] && !clr_vec[rsv_addr_i] && !rsv_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  assign busy_o    = busy_q;
  assign rsv_err_o = rsv_err_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: N combinational read ports with optional write bypass,
// M write ports (highest port wins), optional hardwired-zero r0, busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = ZERO_REG_ON,
  parameter int BYPASS   = BYPASS_ON
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*clog2(NUM_REGS)-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]     wr_data,
  input  logic [NUM_WR-1:0]            wr_clr,
  input  logic                         rsv_en,
  input  logic [clog2(NUM_REGS)-1:0]   rsv_addr,
  output logic                         rsv_err,
  output logic [NUM_REGS-1:0]          busy_vec
);

  localparam int AW = clog2(NUM_REGS);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  // Later ports are applied last, so port NUM_WR-1 wins a same-address conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) mem_q[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0)))
          mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Bypass is gated by rst_n so reads stay zero while reset is held.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*AW +: AW]];
      if ((BYPASS != 0) && rst_n) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]))
            rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0))
        rd_data[i*DATA_W +: DATA_W] = '0;
      rd_busy[i] = busy_vec[rd_addr[i*AW +: AW]];
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_clr_i   (wr_clr),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .busy_o     (busy_vec),
    .rsv_err_o  (rsv_err)
  );

endmodule
